icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache between the pipeline's fetch interface and the memory controller's instruction port. Returns instruction words combinationally on a hit and runs a single-word fill on a miss. The fetch stage stalls on a deasserted `ihit`. Word-granular blocks, write-allocate-free (instruction side is never written by the core).

## Interface
Parameters:
- `SETS`, 16: number of frames; power of two, ≥2. Index width `IDX_W = $clog2(SETS)`. Tag width `TAG_W = 30 - IDX_W`.

Ports:
- `CLK`  in  1  clock. All state changes on the rising edge.
- `RST`  in  1  reset. Synchronous, active-high.
- `imemREN`  in  1  fetch request from the pipeline.
- `imemaddr`  in  32  fetch byte address. Bits [1:0] are ignored.
- `iflush`  in  1  invalidate all frames.
- `ihit`  out  1  `imemload` is valid this cycle.
- `imemload`  out  32  instruction word.
- `iREN`  out  1  memory read request.
- `iaddr`  out  32  memory word address. Bits [1:0] are always 0.
- `iwait`  in  1  memory busy. A low level while `iREN` is high means `iload` is valid.
- `iload`  in  32  memory read data.
- `hit_count`, `miss_count`  out  32 each  present only with `ICACHE_STATS_EN`.

## Operation
- Address split: tag = `imemaddr[31:IDX_W+2]`, index = `imemaddr[IDX_W+1:2]`.
- Per frame: valid (1), tag (`TAG_W`), data (32).
- FSM has 2 states:
  - **IDLE**
    - `ihit = imemREN & valid[idx] & (tag[idx]==addr tag)`.
    - `imemload` = data[idx] on a hit, otherwise 0.
    - On `imemREN` & miss: latch the word address into `miss_addr` and go to FILL.
    - `iREN` = 0.
  - **FILL**
    - `iREN` = 1, `iaddr` = `miss_addr`, `ihit` = 0.
    - When `iwait` = 0: write frame[miss index] with {valid=1, tag, `iload`} and go to IDLE.
- The fill always completes for the latched address, even if `imemaddr` changes (branch redirect) or `imemREN` drops mid-fill. A stale fill is harmless.
- `iflush`:
  - At the edge: all valid bits are cleared.
  - In FILL: the fill is aborted, nothing is written, and the FSM goes to IDLE.
  - `ihit` is forced 0 in a cycle where `iflush` is high.
- Priority: `RST` > `iflush` > fill write.
- No writes from the core. Self-modifying code is handled by software asserting `iflush`.

## Timing
- Reset (`RST` high at an edge):
  - state = IDLE; all valid = 0; `miss_addr` = 0.
  - Outputs: `ihit`=0, `imemload`=0, `iREN`=0, `iaddr`=0, counters=0.
  - Tag and data arrays need no reset.
  - `RST` mid-fill drops `iREN` the following cycle. No frame is written.
- Hit latency: 0 cycles. `ihit` is combinational from `imemaddr` in IDLE.
- Miss latency with a memory that has W wait cycles:
  - Cycle 0: miss detected.
  - Cycles 1..W+1: `iREN` high. Data is captured at the end of cycle W+1.
  - Cycle W+2: `ihit` = 1.
  - Zero-wait memory therefore gives `ihit` on cycle 2.
- `iaddr` and `iREN` are registered-state driven and stable for the whole fill.
- Back-to-back misses re-enter FILL on the cycle after returning to IDLE. There is no idle gap beyond the compare cycle.
- Index aliasing: a fill overwrites the frame unconditionally, regardless of its prior valid/tag.

## Configuration
- `ICACHE_STATS_EN` defined:
  - `hit_count` increments on each IDLE cycle with `ihit` = 1.
  - `miss_count` increments on each IDLE→FILL transition.
  - Both are 32-bit, wrap at 2^32, and are cleared by `RST` only (not by `iflush`).
- Undefined: both ports and the counters are absent. Cache behaviour is identical.

## Structure
- Belongs in `cpu_types_pkg`:
  - `icachef_t` packed struct {tag, idx, bytoff}.
  - `icache_frame_t` {valid, tag, data}.
  - `icache_state_t` enum {IDLE, FILL}.
  - Localparam widths for the default `SETS`.
- Optional sub-module `icache_stats`: counter pair, instantiated only under `ICACHE_STATS_EN`.

## Test plan
- Cold miss at 0x0000_0040:
  - Memory `iwait`=0, `iload`=0x2001_0005.
  - Expect `iREN`=1 and `iaddr`=0x40 on cycle 1.
  - Expect `ihit`=1 and `imemload`=0x2001_0005 on cycle 2.
- Warm hit:
  - Re-fetch 0x40 after the fill.
  - Expect `ihit`=1 in the same cycle and `iREN`=0.
- Conflict (SETS=16):
  - Fill 0x04, then 0x44 (same index 1, different tag).
  - Expect a miss on 0x44, then a miss again on 0x04.
- Redirect mid-fill:
  - Miss on 0x80 with 3 wait cycles; change `imemaddr` to 0x100 on cycle 2.
  - Expect `iaddr` held at 0x80, frame 0 written, then a new fill for 0x100.
- Flush:
  - `iflush` during FILL: expect `iREN`=0 next cycle and no frame written.
  - Any hit address then misses.
- Reset mid-fill:
  - `RST` on fill cycle 2: outputs 0 next cycle.
  - A subsequent fetch of the same address misses.
  - With `ICACHE_STATS_EN`, counters read 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache address split, frame layout and controller states.
// Widths here describe the default 16-frame cache; icache derives its own from SETS.
package cpu_types_pkg;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_stats.sv
// Hit/miss event counters for the instruction cache; compiled only with ICACHE_STATS_EN.
// Both counters wrap at 2^32 and clear on RST only.
`ifdef ICACHE_STATS_EN
module icache_stats (
  input  logic        CLK,
  input  logic        RST,
  input  logic        hit_inc,
  input  logic        miss_inc,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_inc)  hit_count  <= hit_count + 32'd1;
      if (miss_inc) miss_count <= miss_count + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with single-word fills.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = ICACHE_SETS
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t    state, state_n;
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS];
  logic [29:0]      miss_addr;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] fill_idx;
  logic             match;
  logic             miss_start;
  logic             fill_done;

  assign req_tag  = imemaddr[31:IDX_W+2];
  assign req_idx  = imemaddr[IDX_W+1:2];
  assign fill_idx = miss_addr[IDX_W-1:0];
  assign match    = valid[req_idx] && (tags[req_idx] == req_tag);

  // Memory handshake: iREN and iaddr are held steady for the whole fill; the
  // word transfers in any cycle where iREN is high and iwait is low.
  always_comb begin
    state_n    = state;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    miss_start = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        ihit = imemREN && match && !iflush;
        if (ihit) imemload = data[req_idx];
        if (imemREN && !match && !iflush) begin
          miss_start = 1'b1;
          state_n    = FILL;
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = {miss_addr, 2'b00};
        if (iflush) begin
          state_n = IDLE;
        end else if (!iwait) begin
          fill_done = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      valid     <= '0;
      miss_addr <= '0;
    end else begin
      state <= state_n;
      if (miss_start) miss_addr <= imemaddr[31:2];
      if (iflush)         valid           <= '0;
      else if (fill_done) valid[fill_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (!RST && fill_done) begin
      tags[fill_idx] <= miss_addr[29:IDX_W];
      data[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  icache_stats u_stats (
    .CLK        (CLK),
    .RST        (RST),
    .hit_inc    (ihit),
    .miss_inc   (miss_start),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );
`endif

endmodule

// File: tb/tb_icache.sv
// Randomized self-checking bench for icache against an array-based cache model.
// Inputs change on the falling edge; outputs are sampled 1ns later.
`timescale 1ns/1ps
module tb_icache;

  localparam int SETS  = 16;
  localparam int IDX_W = $clog2(SETS);

  logic        CLK = 1'b0;
  logic        RST, imemREN, iflush, iwait;
  logic [31:0] imemaddr, iload;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] exp_q[$];

  bit          m_valid [SETS];
  logic [31:0] m_tag   [SETS];
  logic [31:0] m_data  [SETS];
  logic [31:0] mem_over [logic [31:0]];
  int unsigned exp_hits   = 0;
  int unsigned exp_misses = 0;

  icache #(.SETS(SETS)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .iflush   (iflush),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // clock
  always #5 CLK = ~CLK;

  // reference model helpers
  function automatic int unsigned m_idx(input logic [31:0] a);
    return (a >> 2) % SETS;
  endfunction

  function automatic logic [31:0] m_tagf(input logic [31:0] a);
    return a >> (2 + IDX_W);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == m_tagf(a));
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = a & ~32'd3;
    if (mem_over.exists(wa)) return mem_over[wa];
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic m_clear();
    for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; imemREN = 1'b0; iflush = 1'b0; iwait = 1'b1; iload = '0; imemaddr = '0;
    @(negedge CLK);
    #1;
    check_eq("rst_ihit", ihit, 32'd0);
    check_eq("rst_imemload", imemload, 32'd0);
    check_eq("rst_iREN", iREN, 32'd0);
    check_eq("rst_iaddr", iaddr, 32'd0);
    RST = 1'b0;
    m_clear();
    exp_hits = 0;
    exp_misses = 0;
  endtask

  // Plays memory for W wait cycles then returns the word; optionally redirects
  // the fetch address or asserts iflush on a given fill cycle (0 = never).
  task automatic do_fill(input logic [31:0] a, input int w, input int redir_cyc,
                         input logic [31:0] redir_a, input int flush_cyc);
    for (int k = 1; k <= w + 1; k++) begin
      @(negedge CLK);
      if (k == redir_cyc) imemaddr = redir_a;
      iflush = (k == flush_cyc);
      iwait  = (k <= w) && (k != flush_cyc);
      iload  = iwait ? $urandom : mem_word(a);
      #1;
      check_eq("fill_iREN", iREN, 32'd1);
      check_eq("fill_iaddr", iaddr, a & ~32'd3);
      check_eq("fill_ihit", ihit, 32'd0);
      if (k == flush_cyc) begin
        m_clear();
        return;
      end
    end
    m_valid[m_idx(a)] = 1'b1;
    m_tag[m_idx(a)]   = m_tagf(a);
    m_data[m_idx(a)]  = mem_word(a);
  endtask

  task automatic fetch(input logic [31:0] a, input int w);
    bit          eh;
    logic [31:0] e;
    eh = m_hit(a);
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = a; iflush = 1'b0; iwait = 1'b1; iload = $urandom;
    #1;
    check_eq("ihit", ihit, {31'd0, eh});
    check_eq("idle_iREN", iREN, 32'd0);
    if (eh) begin
      check_eq("hit_data", imemload, m_data[m_idx(a)]);
      exp_hits++;
    end else begin
      check_eq("miss_load", imemload, 32'd0);
      exp_misses++;
      exp_q.push_back(mem_word(a));
      do_fill(a, w, 0, 32'd0, 0);
      @(negedge CLK);
      iwait = 1'b1; iload = $urandom;
      #1;
      e = exp_q.pop_front();
      check_eq("fill_then_hit", ihit, 32'd1);
      check_eq("fill_then_data", imemload, e);
      check_eq("fill_then_iREN", iREN, 32'd0);
      exp_hits++;
    end
  endtask

  task automatic idle_slot();
    @(negedge CLK);
    imemREN = 1'b0; imemaddr = $urandom; iflush = 1'b0; iwait = 1'b1; iload = $urandom;
    #1;
    check_eq("idle_ihit", ihit, 32'd0);
    check_eq("idle_iREN2", iREN, 32'd0);
    check_eq("idle_load", imemload, 32'd0);
  endtask

  // Flush while requesting a (possibly cached) address: no hit that cycle, no fill.
  task automatic flush_idle(input logic [31:0] a);
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = a; iflush = 1'b1; iwait = 1'b1;
    #1;
    check_eq("flush_ihit", ihit, 32'd0);
    check_eq("flush_load", imemload, 32'd0);
    m_clear();
    @(negedge CLK);
    imemREN = 1'b0; iflush = 1'b0;
    #1;
    check_eq("flush_iREN", iREN, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] bases [4];
    bases[0] = 32'h0000_0000;
    bases[1] = 32'h0000_0040;
    bases[2] = 32'h8000_0000;
    bases[3] = 32'hABCD_E000;
    return bases[$urandom_range(0, 3)] | (32'($urandom_range(0, SETS - 1)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] e;
    RST = 1'b1; imemREN = 1'b0; iflush = 1'b0; iwait = 1'b1; iload = '0; imemaddr = '0;
    mem_over[32'h0000_0040] = 32'h2001_0005;
    do_reset();

    // cold miss then warm hit
    fetch(32'h0000_0040, 0);
    fetch(32'h0000_0040, 0);
    fetch(32'h0000_0042, 2);

    // conflict on index 1
    fetch(32'h0000_0004, 1);
    fetch(32'h0000_0044, 0);
    fetch(32'h0000_0004, 0);

    // flush during FILL aborts without writing
    fetch(32'h0000_0300, 0);
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h0000_0444; iflush = 1'b0; iwait = 1'b1;
    #1;
    check_eq("pre_flush_miss", ihit, 32'd0);
    exp_misses++;
    do_fill(32'h0000_0444, 3, 0, 32'd0, 2);
    @(negedge CLK);
    imemREN = 1'b0; iflush = 1'b0; iwait = 1'b0; iload = 32'hDEAD_BEEF;
    #1;
    check_eq("abort_iREN", iREN, 32'd0);
    check_eq("abort_ihit", ihit, 32'd0);
    fetch(32'h0000_0300, 0);

    // redirect mid-fill: the 0x80 fill completes, then 0x100 fills the same frame
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h0000_0080; iflush = 1'b0; iwait = 1'b1;
    #1;
    check_eq("redir_miss", ihit, {31'd0, m_hit(32'h0000_0080)});
    exp_misses++;
    do_fill(32'h0000_0080, 3, 2, 32'h0000_0100, 0);
    @(negedge CLK);
    iwait = 1'b1;
    #1;
    check_eq("redir_new_miss", ihit, {31'd0, m_hit(32'h0000_0100)});
    check_eq("redir_idle_iREN", iREN, 32'd0);
    exp_misses++;
    exp_q.push_back(mem_word(32'h0000_0100));
    do_fill(32'h0000_0100, 0, 0, 32'd0, 0);
    @(negedge CLK);
    #1;
    e = exp_q.pop_front();
    check_eq("redir_hit", ihit, 32'd1);
    check_eq("redir_data", imemload, e);
    exp_hits++;
    fetch(32'h0000_0080, 1);

    // flush while fetching a cached address
    flush_idle(32'h0000_0080);
    fetch(32'h0000_0080, 0);

    // reset on fill cycle 2 with the memory word ready: nothing written
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h0000_0200; iflush = 1'b0; iwait = 1'b1;
    #1;
    exp_misses++;
    check_eq("rstfill_miss", ihit, {31'd0, m_hit(32'h0000_0200)});
    @(negedge CLK);
    iwait = 1'b1;
    #1;
    check_eq("rstfill_c1_iREN", iREN, 32'd1);
    @(negedge CLK);
    RST = 1'b1; iwait = 1'b0; iload = mem_word(32'h0000_0200);
    #1;
    check_eq("rstfill_c2_iREN", iREN, 32'd1);
    @(negedge CLK);
    RST = 1'b0; imemREN = 1'b0; iwait = 1'b1;
    #1;
    m_clear();
    exp_hits = 0;
    exp_misses = 0;
    check_eq("rstfill_iREN", iREN, 32'd0);
    check_eq("rstfill_iaddr", iaddr, 32'd0);
    check_eq("rstfill_ihit", ihit, 32'd0);
    check_eq("rstfill_load", imemload, 32'd0);
`ifdef ICACHE_STATS_EN
    check_eq("rstfill_hits", hit_count, 32'd0);
    check_eq("rstfill_misses", miss_count, 32'd0);
`endif
    fetch(32'h0000_0200, 0);
    fetch(32'h0000_0200, 0);

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0:       idle_slot();
        1:       flush_idle(rand_addr());
        default: fetch(rand_addr(), $urandom_range(0, 3));
      endcase
    end

`ifdef ICACHE_STATS_EN
    check_eq("hit_count", hit_count, exp_hits);
    check_eq("miss_count", miss_count, exp_misses);
`endif
    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
